// File: rtl/fetch_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and instruction memory (slave).
interface fetch_if;
  logic        INST_RDEN;
  logic [31:0] INST_ADDR;
  logic        INST_READY;
  logic        INST_RVALID;
  logic [31:0] INST_RDATA;

  modport master (output INST_RDEN, INST_ADDR, input INST_READY, INST_RVALID, INST_RDATA);
  modport slave  (input INST_RDEN, INST_ADDR, output INST_READY, INST_RVALID, INST_RDATA);
endinterface

// File: rtl/fetch.sv
// RV32I fetch stage: credit-limited in-order requests, instruction FIFO, redirect with stale-response drop.
// Optional macro FETCH_BYPASS_EN: present a response straight to decode when the FIFO is empty.
module fetch #(
  parameter logic [31:0] START_ADDR = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           STALL,
  input  logic           FLUSH,
  input  logic [31:0]    NEW_PC,
  fetch_if.master        mem,
  output logic [31:0]    I_PC,
  output logic [31:0]    I_INST,
  output logic           I_VALID
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;
  typedef logic [CW:0]   sum_t;

  logic [31:0] pc_reg, rsp_pc_reg;
  cnt_t        inflight_reg, drop_reg, count_reg;
  ptr_t        wr_ptr_reg, rd_ptr_reg;
  logic [31:0] fifo_pc_mem   [FIFO_DEPTH];
  logic [31:0] fifo_inst_mem [FIFO_DEPTH];
  logic [31:0] i_pc_reg, i_inst_reg;
  logic        i_valid_reg;

  logic        flush_act, credit_ok, rden, issue;
  logic        rsp_valid, rsp_keep, bypass_hit, bypass_take;
  logic        push, pop;
  logic [31:0] flush_target;
  sum_t        used_sum;
  cnt_t        count_after_pop, count_next;
  ptr_t        rd_ptr_next;
  logic [31:0] head_pc, head_inst;
  logic        unused_newpc_lsb;

  assign unused_newpc_lsb = ^NEW_PC[1:0];
  assign flush_target     = {NEW_PC[31:2], 2'b00};
  assign flush_act        = FLUSH && !STALL;
  assign used_sum         = {1'b0, inflight_reg} + {1'b0, count_reg};
  assign credit_ok        = used_sum < sum_t'(FIFO_DEPTH);
  // Gated by RST so the request line is low while reset is held.
  assign rden             = RST && credit_ok && !flush_act;
  assign issue            = rden && mem.INST_READY;

  // A response with nothing outstanding is a protocol error and is ignored entirely.
  assign rsp_valid = mem.INST_RVALID && (inflight_reg != '0);
  assign rsp_keep  = rsp_valid && (drop_reg == '0) && !flush_act;

`ifdef FETCH_BYPASS_EN
  assign bypass_hit  = rsp_keep && (count_reg == '0);
  assign bypass_take = bypass_hit && !STALL;
`else
  assign bypass_hit  = 1'b0;
  assign bypass_take = 1'b0;
`endif

  assign push = rsp_keep && !bypass_take;
  assign pop  = i_valid_reg && !STALL;

  assign mem.INST_RDEN = rden;
  assign mem.INST_ADDR = pc_reg;

  // Head after this edge: the freshly pushed word when the FIFO drains to it, otherwise the stored entry.
  always_comb begin
    count_after_pop = count_reg - cnt_t'(pop);
    rd_ptr_next     = rd_ptr_reg + ptr_t'(pop);
    count_next      = flush_act ? '0 : (count_after_pop + cnt_t'(push));
    head_pc         = rsp_pc_reg;
    head_inst       = mem.INST_RDATA;
    if (count_after_pop != '0) begin
      head_pc   = fifo_pc_mem[rd_ptr_next];
      head_inst = fifo_inst_mem[rd_ptr_next];
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_pc_mem[wr_ptr_reg]   <= rsp_pc_reg;
      fifo_inst_mem[wr_ptr_reg] <= mem.INST_RDATA;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pc_reg       <= START_ADDR;
      rsp_pc_reg   <= START_ADDR;
      inflight_reg <= '0;
      drop_reg     <= '0;
      count_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
    end else begin
      if (flush_act) begin
        pc_reg     <= flush_target;
        rsp_pc_reg <= flush_target;
        // Everything still outstanding belongs to the abandoned path.
        drop_reg   <= inflight_reg - cnt_t'(rsp_valid);
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (issue)
          pc_reg <= pc_reg + 32'd4;
        if (rsp_keep)
          rsp_pc_reg <= rsp_pc_reg + 32'd4;
        if (rsp_valid && (drop_reg != '0))
          drop_reg <= drop_reg - cnt_t'(1);
        if (push)
          wr_ptr_reg <= wr_ptr_reg + ptr_t'(1);
        rd_ptr_reg <= rd_ptr_next;
      end
      inflight_reg <= inflight_reg + cnt_t'(issue) - cnt_t'(rsp_valid);
      count_reg    <= count_next;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      i_pc_reg    <= '0;
      i_inst_reg  <= '0;
      i_valid_reg <= 1'b0;
    end else if (flush_act) begin
      i_valid_reg <= 1'b0;
    end else begin
      i_valid_reg <= (count_next != '0);
      if (count_next != '0) begin
        i_pc_reg   <= head_pc;
        i_inst_reg <= head_inst;
      end else if (bypass_take) begin
        i_pc_reg   <= rsp_pc_reg;
        i_inst_reg <= mem.INST_RDATA;
      end
    end
  end

  assign I_VALID = i_valid_reg || bypass_hit;
  assign I_PC    = bypass_hit ? rsp_pc_reg     : i_pc_reg;
  assign I_INST  = bypass_hit ? mem.INST_RDATA : i_inst_reg;

  // Credit accounting should make a push into a full buffer impossible.
  a_no_overflow: assert property (@(posedge CLK) disable iff (!RST)
                                  !(push && !pop && (count_reg == cnt_t'(FIFO_DEPTH))));

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: reset, vector table, directed corner sequences and random traffic vs a queue-based model.
module tb_fetch;
  localparam logic [31:0] START = 32'h0000_0100;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        STALL = 1'b0;
  logic        FLUSH = 1'b0;
  logic [31:0] NEW_PC = '0;
  logic [31:0] I_PC, I_INST;
  logic        I_VALID;

  fetch_if bus();

  fetch #(.START_ADDR(START), .FIFO_DEPTH(2)) dut (
    .CLK(CLK), .RST(RST), .STALL(STALL), .FLUSH(FLUSH), .NEW_PC(NEW_PC),
    .mem(bus), .I_PC(I_PC), .I_INST(I_INST), .I_VALID(I_VALID)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Memory model: in-order queue of accepted requests tagged with the redirect epoch they were issued in.
  typedef struct { logic [31:0] addr; int due; int epoch; } req_t;
  req_t        q[$];
  int          cyc = 0;
  int          epoch = 0;
  int          buffered = 0;
  logic [31:0] exp_pc = START;
  logic [31:0] exp_issue = START;
  bit          mem_hold = 1'b0;
  bit          lat_rand = 1'b0;
  int          lat_fixed = 0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0050_0093;
    if (a == 32'h0000_0300) return 32'h0000_0013;
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    RST = 1'b0; STALL = 1'b0; FLUSH = 1'b0; NEW_PC = '0;
    bus.INST_READY = 1'b0; bus.INST_RVALID = 1'b0; bus.INST_RDATA = '0;
    q.delete();
    buffered = 0; epoch++; exp_pc = START; exp_issue = START;
    #1;
    chk_b("rst_rden",  bus.INST_RDEN, 1'b0);
    chk  ("rst_addr",  bus.INST_ADDR, START);
    chk  ("rst_i_pc",  I_PC, 32'h0);
    chk  ("rst_i_inst", I_INST, 32'h0);
    chk_b("rst_i_valid", I_VALID, 1'b0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
  endtask

  // One clock of traffic: drive at negedge, sample 1 time unit later, then advance the model past the edge.
  task automatic step(input bit stall, input bit flush, input logic [31:0] newpc,
                      input bit ready, input bit spurious);
    bit rsp_now, flush_act, kept, visible, consume, fire;
    int rsp_ep, lat;
    @(negedge CLK);
    rsp_now = 1'b0;
    rsp_ep  = -1;
    if (spurious) begin
      bus.INST_RVALID = 1'b1; bus.INST_RDATA = 32'hDEAD_BEEF;
    end else if (!mem_hold && q.size() > 0 && q[0].due <= cyc) begin
      rsp_now = 1'b1; rsp_ep = q[0].epoch;
      bus.INST_RVALID = 1'b1; bus.INST_RDATA = inst_of(q[0].addr);
    end else begin
      bus.INST_RVALID = 1'b0; bus.INST_RDATA = $urandom;
    end
    STALL = stall; FLUSH = flush; NEW_PC = newpc; bus.INST_READY = ready;
    #1;
    flush_act = flush && !stall;
    kept      = rsp_now && (rsp_ep == epoch) && !flush_act;
    visible   = (buffered > 0) || (BYP && kept);
    consume   = visible && !stall && !flush_act;
    chk_b("rden", bus.INST_RDEN, ((q.size() + buffered) < 2) && !flush_act);
    chk  ("inst_addr", bus.INST_ADDR, exp_issue);
    chk_b("i_valid", I_VALID, visible);
    if (visible) begin
      chk("i_pc", I_PC, exp_pc);
      chk("i_inst", I_INST, inst_of(exp_pc));
    end
    fire = bus.INST_RDEN && ready;
    if (rsp_now) void'(q.pop_front());
    if (fire) begin
      lat = lat_rand ? int'($urandom_range(0, 3)) : lat_fixed;
      q.push_back('{addr: bus.INST_ADDR, due: cyc + 1 + lat, epoch: epoch});
      exp_issue += 32'd4;
    end
    if (consume) begin
      $display("cycle %0d: decode takes pc %08h inst %08h", cyc, I_PC, I_INST);
      exp_pc += 32'd4;
    end
    if (flush_act) begin
      epoch++;
      buffered  = 0;
      exp_pc    = {newpc[31:2], 2'b00};
      exp_issue = exp_pc;
    end else begin
      buffered = buffered + int'(kept) - int'(consume);
    end
    cyc++;
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && !(q.size() == 0 && buffered == 0); k++)
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("drain_bound", q.size() + buffered, 32'h0);
  endtask

  typedef struct {
    bit stall; bit flush; logic [31:0] new_pc; bit ready; bit rvalid; logic [31:0] rdata;
    bit e_rden; logic [31:0] e_addr; bit e_valid; logic [31:0] e_pc;
  } vec_t;
  vec_t tbl[13];

  initial begin
    logic [31:0] held;
    bit          found;

    bus.INST_READY = 1'b0; bus.INST_RVALID = 1'b0; bus.INST_RDATA = '0;

    // Reset release, streaming with 1-cycle memory, a short stall, then a redirect to 0x203.
    tbl[0]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,              1'b1, 32'h100, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, inst_of(32'h100),   1'b1, 32'h104, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, inst_of(32'h104),   1'b0, 32'h108, 1'b1, 32'h100};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,              1'b1, 32'h108, 1'b1, 32'h104};
    tbl[4]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, inst_of(32'h108),   1'b1, 32'h10C, 1'b0, 32'h0};
    tbl[5]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, inst_of(32'h10C),   1'b0, 32'h110, 1'b1, 32'h108};
    tbl[6]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,              1'b0, 32'h110, 1'b1, 32'h108};
    tbl[7]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,              1'b0, 32'h110, 1'b1, 32'h108};
    tbl[8]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,              1'b1, 32'h110, 1'b1, 32'h10C};
    tbl[9]  = '{1'b0, 1'b1, 32'h203, 1'b1, 1'b0, 32'h0,              1'b0, 32'h114, 1'b0, 32'h0};
    tbl[10] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, inst_of(32'h110),   1'b1, 32'h200, 1'b0, 32'h0};
    tbl[11] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, inst_of(32'h200),   1'b1, 32'h204, 1'b0, 32'h0};
    tbl[12] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,              1'b0, 32'h208, 1'b1, 32'h200};

    apply_reset();

`ifndef FETCH_BYPASS_EN
    for (int i = 0; i < 13; i++) begin
      @(negedge CLK);
      STALL = tbl[i].stall; FLUSH = tbl[i].flush; NEW_PC = tbl[i].new_pc;
      bus.INST_READY = tbl[i].ready; bus.INST_RVALID = tbl[i].rvalid; bus.INST_RDATA = tbl[i].rdata;
      #1;
      $display("vector %0d: rden %0b addr %08h valid %0b pc %08h inst %08h",
               i, bus.INST_RDEN, bus.INST_ADDR, I_VALID, I_PC, I_INST);
      chk_b($sformatf("tbl%0d_rden", i), bus.INST_RDEN, tbl[i].e_rden);
      chk  ($sformatf("tbl%0d_addr", i), bus.INST_ADDR, tbl[i].e_addr);
      chk_b($sformatf("tbl%0d_valid", i), I_VALID, tbl[i].e_valid);
      if (tbl[i].e_valid) begin
        chk($sformatf("tbl%0d_pc", i), I_PC, tbl[i].e_pc);
        chk($sformatf("tbl%0d_inst", i), I_INST, inst_of(tbl[i].e_pc));
      end
    end
`endif

    // Back-pressure: stall for 5 cycles mid-stream.
    apply_reset();
    lat_rand = 1'b0; lat_fixed = 0;
    repeat (12) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    held = '0;
    for (int s = 0; s < 5; s++) begin
      step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      if (s == 0) held = I_PC;
    end
    chk  ("stall_hold_pc", I_PC, held);
    chk_b("stall_rden_low", bus.INST_RDEN, 1'b0);
    repeat (10) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

    // Flush with two requests in flight; the stalled attempt must be ignored.
    apply_reset();
    lat_fixed = 4;
    repeat (2) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 32'h203, 1'b1, 1'b0);
    chk("stalled_flush_ignored", bus.INST_ADDR, 32'h108);
    step(1'b0, 1'b1, 32'h203, 1'b1, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      if (I_VALID) begin
        found = 1'b1;
        chk("flush_first_pc", I_PC, 32'h200);
      end
    end
    chk_b("flush_valid_seen", found, 1'b1);

    // Address wrap, then a memory that withholds READY and responses for 10 cycles.
    apply_reset();
    lat_fixed = 0;
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    mem_hold = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      chk  ("wrap_addr", bus.INST_ADDR, 32'h0);
      chk_b("wrap_no_valid", I_VALID, 1'b0);
    end
    mem_hold = 1'b0;
    repeat (12) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

    // Response with nothing outstanding is ignored and must not underflow the counters.
    drain();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk_b("spurious_no_valid", I_VALID, 1'b0);
    repeat (10) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

    // Response latency into an empty FIFO.
    apply_reset();
    step(1'b0, 1'b1, 32'h300, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk_b("latency_same_cycle", I_VALID, BYP);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk_b("latency_next_cycle", I_VALID, !BYP);
    chk  ("latency_inst", I_INST, 32'h0000_0013);

    // Random traffic against the model.
    apply_reset();
    lat_rand = 1'b1;
    for (int n = 0; n < 2500; n++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                         : ($urandom & 32'h0000_3FFF);
      step($urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0, tgt,
           $urandom_range(0, 3) != 0, 1'b0);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
